alu_mdu: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mdu_if.sv | 31 +++
 rtl/mdu_iter.sv | 135 +++++++++++++
 rtl/alu_mdu.sv | 67 ++++++
 tb/tb_alu_mdu.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
// Holds the ALUCtr and md_op codes and the MDU sequencer state encoding.
package alu_pkg;

  localparam int ALU_CTR_W = 4;
  localparam int MD_OP_W   = 3;

  // ALUCtr encodings
  localparam logic [ALU_CTR_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTR_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTR_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTR_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [ALU_CTR_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [ALU_CTR_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_CTR_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTR_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CTR_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [ALU_CTR_W-1:0] ALU_SLTU = 4'b1001;
  localparam logic [ALU_CTR_W-1:0] ALU_NOR  = 4'b1100;

  // md_op encodings
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'b000;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'b001;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'b010;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'b011;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'b100;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Bus between the EX-stage controller (master) and alu_mdu (slave).
// ALU: SrcA/SrcB/ALUCtr in, ALURes/Zero/Overflow out.
// MDU: md_op/md_start in, md_busy/md_done/hi/lo out.
interface alu_mdu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]     SrcA;
  logic [WIDTH-1:0]     SrcB;
  logic [ALU_CTR_W-1:0] ALUCtr;
  logic [WIDTH-1:0]     ALURes;
  logic                 Zero;
  logic                 Overflow;
  logic [MD_OP_W-1:0]   md_op;
  logic                 md_start;
  logic                 md_busy;
  logic                 md_done;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output SrcA, SrcB, ALUCtr, md_op, md_start,
    input  ALURes, Zero, Overflow, md_busy, md_done, hi, lo
  );

  modport slave (
    input  SrcA, SrcB, ALUCtr, md_op, md_start,
    output ALURes, Zero, Overflow, md_busy, md_done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports: clk, rst_n (async, active-low); a_i/b_i operands; op_i md_op code;
// start_i request; busy_o while iterating; done_o one-cycle pulse on
// result write; hi_o/lo_o the HI/LO registers.
// One shift-add or restoring-subtract step per RUN cycle on operand
// magnitudes; FIX applies the sign correction and writes HI/LO.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [MD_OP_W-1:0] op_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] p_q;      // {remainder/product-high, quotient/product-low}
  logic [WIDTH-1:0]   b_q;      // multiplicand or divisor magnitude
  logic               is_div_q, sgn_q, rneg_q, dz_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_muldiv, is_signed, is_div, launch, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] p_step, prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix, quot, rem;

  always_comb begin
    is_muldiv = (op_i == MD_MULT) || (op_i == MD_MULTU) ||
                (op_i == MD_DIV)  || (op_i == MD_DIVU);
    is_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    is_div    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
    launch    = start_i && is_muldiv && (state_q == MD_IDLE);
    a_neg     = is_signed && a_i[WIDTH-1];
    b_neg     = is_signed && b_i[WIDTH-1];
    // MIN_INT negates to itself, which is its correct unsigned magnitude
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
  end

  // One iteration step for each algorithm
  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (!is_div_q) begin
      p_step = {mul_sum, p_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      p_step = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end else begin
      p_step = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction; a zero divisor yields all-ones quotient and the
  // remainder path naturally restores the original dividend.
  always_comb begin
    prod_fix = sgn_q ? -p_q : p_q;
    quot     = p_q[WIDTH-1:0];
    rem      = p_q[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      hi_fix = rneg_q ? -rem : rem;
      lo_fix = dz_q ? '1 : (sgn_q ? -quot : quot);
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (launch) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != MD_IDLE);
    done_o = done_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

  always_ff @(posedge clk) begin
    if (launch) begin
      p_q      <= {{WIDTH{1'b0}}, a_mag};
      b_q      <= b_mag;
      is_div_q <= is_div;
      sgn_q    <= a_neg ^ b_neg;
      rneg_q   <= is_div && a_neg;
      dz_q     <= is_div && (b_i == '0);
    end else if (state_q == MD_RUN) begin
      p_q <= p_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= (state_q == MD_FIX);
      if (launch)                 cnt_q <= '0;
      else if (state_q == MD_RUN) cnt_q <= cnt_q + CW'(1);
      if (state_q == MD_FIX) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end else if ((state_q == MD_IDLE) && start_i) begin
        if (op_i == MD_MTHI) hi_q <= a_i;
        if (op_i == MD_MTLO) lo_q <= a_i;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage datapath: combinational ALU plus iterative multiply/divide unit.
// Ports: clk, rst_n (async, active-low); bus (alu_mdu_if.slave) carrying
// SrcA/SrcB/ALUCtr -> ALURes/Zero/Overflow and md_op/md_start ->
// md_busy/md_done/hi/lo. The ALU stays valid while the MDU is busy.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] a, b, sum, diff, res;
  logic [SHW-1:0]   shamt;
  logic             ovf;

  always_comb begin
    a     = bus.SrcA;
    b     = bus.SrcB;
    shamt = a[SHW-1:0];
    sum   = a + b;
    diff  = a - b;
    res   = '0;
    ovf   = 1'b0;
    case (bus.ALUCtr)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_ADD: begin
        res = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res = diff;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  res = b << shamt;
      ALU_SRL:  res = b >> shamt;
      ALU_SRA:  res = $unsigned($signed(b) >>> shamt);
      default:  res = '0;
    endcase
  end

  assign bus.ALURes   = res;
  assign bus.Zero     = (res == '0);
  assign bus.Overflow = ovf;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_i    (bus.SrcA),
    .b_i    (bus.SrcB),
    .op_i   (bus.md_op),
    .start_i(bus.md_start),
    .busy_o (bus.md_busy),
    .done_o (bus.md_done),
    .hi_o   (bus.hi),
    .lo_o   (bus.lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu at WIDTH=32 and WIDTH=16.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus32 ();
  alu_mdu_if #(.WIDTH(16)) bus16 ();

  alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  alu_mdu #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    string       name;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        o;
  } alu_vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference results built from native signed/unsigned arithmetic
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb, sq, sr;
    sa = a;
    sb = b;
    case (op)
      MD_MULT: begin
        sp = 64'(sa) * 64'(sb);
        return sp;
      end
      MD_MULTU: return {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus32.md_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=%h exp=none", {bus32.hi, bus32.lo});
      end else begin
        check("md_result", {bus32.hi, bus32.lo}, exp_q.pop_front());
      end
    end
  end

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus32.md_op    = op;
    bus32.SrcA     = a;
    bus32.SrcB     = b;
    bus32.md_start = 1'b1;
    @(posedge clk);
    #1 bus32.md_start = 1'b0;
  endtask

  // Waits for done; optionally fires an extra start at cycle inj while busy
  task automatic wait_done32(input int inj, output int nbusy);
    int  cyc;
    bit  got;
    nbusy = 0;
    got   = 0;
    cyc   = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (inj > 0 && cyc == inj) begin
        bus32.md_op    = MD_DIVU;
        bus32.SrcA     = 32'd100;
        bus32.SrcB     = 32'd3;
        bus32.md_start = 1'b1;
      end else if (inj > 0 && cyc == inj + 1) begin
        bus32.md_start = 1'b0;
      end
      if (bus32.md_done) got = 1;
      else if (bus32.md_busy) nbusy++;
    end
    check("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    check("done_one_cycle", 64'(bus32.md_done), 64'd0);
    check("idle_after_done", 64'(bus32.md_busy), 64'd0);
  endtask

  task automatic run16(input string nm, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eh, input logic [15:0] el);
    int cyc;
    int nbusy;
    bit got;
    @(negedge clk);
    bus16.md_op    = op;
    bus16.SrcA     = a;
    bus16.SrcB     = b;
    bus16.md_start = 1'b1;
    @(posedge clk);
    #1 bus16.md_start = 1'b0;
    cyc = 0; nbusy = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus16.md_done) got = 1;
      else if (bus16.md_busy) nbusy++;
    end
    check({nm, "_done"}, 64'(got), 64'd1);
    check({nm, "_busy_cycles"}, 64'(nbusy), 64'd17);
    check({nm, "_hi"}, 64'(bus16.hi), 64'(eh));
    check({nm, "_lo"}, 64'(bus16.lo), 64'(el));
  endtask

  initial begin
    alu_vec_t tab[$];
    int nb;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    bus32.SrcA = '0; bus32.SrcB = '0; bus32.ALUCtr = '0;
    bus32.md_op = MD_MULT; bus32.md_start = 1'b0;
    bus16.SrcA = '0; bus16.SrcB = '0; bus16.ALUCtr = '0;
    bus16.md_op = MD_MULT; bus16.md_start = 1'b0;

    #2;
    check("rst_busy", 64'(bus32.md_busy), 64'd0);
    check("rst_done", 64'(bus32.md_done), 64'd0);
    check("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tab.push_back('{"and",   ALU_AND,  32'h8000_0000, 32'h1, 32'h0,          1'b1, 1'b0});
    tab.push_back('{"or",    ALU_OR,   32'h8000_0000, 32'h1, 32'h8000_0001,  1'b0, 1'b0});
    tab.push_back('{"add",   ALU_ADD,  32'h8000_0000, 32'h1, 32'h8000_0001,  1'b0, 1'b0});
    tab.push_back('{"sub",   ALU_SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF,  1'b0, 1'b1});
    tab.push_back('{"slt",   ALU_SLT,  32'h8000_0000, 32'h1, 32'h1,          1'b0, 1'b0});
    tab.push_back('{"sltu",  ALU_SLTU, 32'h8000_0000, 32'h1, 32'h0,          1'b1, 1'b0});
    tab.push_back('{"nor",   ALU_NOR,  32'h8000_0000, 32'h1, 32'h7FFF_FFFE,  1'b0, 1'b0});
    tab.push_back('{"xor",   ALU_XOR,  32'h8000_0000, 32'h1, 32'h8000_0001,  1'b0, 1'b0});
    tab.push_back('{"sll0",  ALU_SLL,  32'h8000_0000, 32'h1, 32'h1,          1'b0, 1'b0});
    tab.push_back('{"srl0",  ALU_SRL,  32'h8000_0000, 32'h1, 32'h1,          1'b0, 1'b0});
    tab.push_back('{"sra0",  ALU_SRA,  32'h8000_0000, 32'h1, 32'h1,          1'b0, 1'b0});
    tab.push_back('{"addov", ALU_ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000,  1'b0, 1'b1});
    tab.push_back('{"addwz", ALU_ADD,  32'hFFFF_FFFF, 32'h1, 32'h0,          1'b1, 1'b0});
    tab.push_back('{"subeq", ALU_SUB,  32'h1234_5678, 32'h1234_5678, 32'h0,  1'b1, 1'b0});
    tab.push_back('{"sll4",  ALU_SLL,  32'h4,  32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0});
    tab.push_back('{"srl4",  ALU_SRL,  32'h4,  32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0});
    tab.push_back('{"sra4",  ALU_SRA,  32'h4,  32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0});
    tab.push_back('{"sltn",  ALU_SLT,  32'h1,  32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0});
    tab.push_back('{"sltun", ALU_SLTU, 32'h1,  32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0});
    tab.push_back('{"undef", 4'b1111,  32'hFFFF_FFFF, 32'h5, 32'h0,          1'b1, 1'b0});

    foreach (tab[i]) begin
      bus32.ALUCtr = tab[i].ctr;
      bus32.SrcA   = tab[i].a;
      bus32.SrcB   = tab[i].b;
      #1;
      check({"alu_", tab[i].name, "_res"}, 64'(bus32.ALURes), 64'(tab[i].res));
      check({"alu_", tab[i].name, "_zero"}, 64'(bus32.Zero), 64'(tab[i].z));
      check({"alu_", tab[i].name, "_ovf"}, 64'(bus32.Overflow), 64'(tab[i].o));
    end

    // MULT -3*7 with a second start injected mid-operation
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    issue32(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    bus32.ALUCtr = ALU_XOR;
    bus32.SrcA   = 32'hF0F0_0000;
    bus32.SrcB   = 32'h0F0F_0000;
    #1 check("alu_while_busy", 64'(bus32.ALURes), 64'hFF_FF00_00);
    wait_done32(5, nb);
    check("mult_busy_cycles", 64'(nb), 64'd33);

    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done32(0, nb);

    exp_q.push_back({32'd7, 32'hFFFF_FFFF});
    issue32(MD_DIVU, 32'd7, 32'd0);
    wait_done32(0, nb);

    exp_q.push_back({32'h0, 32'h8000_0000});
    issue32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done32(0, nb);

    exp_q.push_back({32'hFFFF_FFF9, 32'hFFFF_FFFF});
    issue32(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done32(0, nb);

    // MTHI / MTLO: immediate write, no busy, no done
    issue32(MD_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", 64'(bus32.hi), 64'h1234);
    check("mthi_lo_kept", 64'(bus32.lo), 64'hFFFF_FFFF);
    check("mthi_busy", 64'(bus32.md_busy), 64'd0);
    check("mthi_done", 64'(bus32.md_done), 64'd0);
    issue32(MD_MTLO, 32'hABCD, 32'd0);
    check("mtlo_lo", 64'(bus32.lo), 64'hABCD);
    check("mtlo_hi_kept", 64'(bus32.hi), 64'h1234);

    // Randomised ops against the native-arithmetic model
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      exp_q.push_back(md_model(rop, ra, rb));
      issue32(rop, ra, rb);
      wait_done32(0, nb);
      check("rand_busy_cycles", 64'(nb), 64'd33);
    end

    // Reset during DIVU abandons it with no done pulse
    issue32(MD_DIVU, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus32.md_busy), 64'd0);
    check("midrst_hilo", {bus32.hi, bus32.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.md_done || bus32.md_busy) nb++;
    end
    check("midrst_quiet", 64'(nb), 64'd0);
    exp_q.push_back({32'd6, 32'd142});
    issue32(MD_DIVU, 32'd1000, 32'd7);
    wait_done32(0, nb);
    check("postrst_busy_cycles", 64'(nb), 64'd33);

    // WIDTH=16 instance
    bus16.ALUCtr = ALU_SRA;
    bus16.SrcA   = 16'd15;
    bus16.SrcB   = 16'h8000;
    #1 check("alu16_sra15", 64'(bus16.ALURes), 64'hFFFF);
    run16("multu16", MD_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    run16("div16", MD_DIV, 16'hFFF9, 16'd2, 16'hFFFF, 16'hFFFD);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
